// File: rtl/output_port_vc_credit.sv
// Sender-side credit tracker and round-robin VC allocator for one router output port.
// Holds a credit counter per downstream VC, grants a credited VC per flit and launches it one cycle later.
module output_port_vc_credit #(
    parameter type flit_payload_t = logic [256-1:0],
    parameter type flit_dec_t     = logic [31:0],
    parameter int  VC_NUM          = 4,
    parameter int  VC_NUM_IDX_W    = VC_NUM > 1 ? $clog2(VC_NUM) : 1,
    parameter int  VC_ID_NUM_MAX_W = VC_NUM_IDX_W + 1,
    parameter int  VC_DEPTH        = 2,
    parameter int  CRD_W           = $clog2(VC_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_vld_i,
    input  flit_payload_t               req_flit_i,
    input  flit_dec_t                   req_dec_i,
    input  logic [VC_NUM-1:0]           req_vc_mask_i,
    output logic                        req_rdy_o,
    output logic                        flit_v_o,
    output flit_payload_t               flit_o,
    output flit_dec_t                   flit_dec_o,
    output logic [VC_NUM_IDX_W-1:0]     flit_vc_id_o,
    input  logic                        lcrd_v_i,
    input  logic [VC_ID_NUM_MAX_W-1:0]  lcrd_id_i,
    output logic [VC_NUM*CRD_W-1:0]     crd_cnt_o,
    output logic                        crd_err_o
);

    localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(VC_DEPTH);

    logic [CRD_W-1:0]        crd_q [VC_NUM];
    logic [CRD_W-1:0]        crd_d [VC_NUM];
    logic [VC_NUM_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic                    crd_err_q, crd_err_d;
    logic                    flit_v_q, flit_v_d;
    flit_payload_t           flit_q, flit_d;
    flit_dec_t               flit_dec_q, flit_dec_d;
    logic [VC_NUM_IDX_W-1:0] vc_id_q, vc_id_d;

    logic [VC_NUM-1:0]       eligible;
    logic [VC_NUM-1:0]       grant_oh;
    logic [VC_NUM_IDX_W-1:0] grant_idx;
    logic [VC_NUM_IDX_W-1:0] scan_idx;
    logic                    grant_found;
    logic                    hs;
    logic [31:0]             lcrd_id_ext;
    logic                    lcrd_in_range;
    logic [VC_NUM-1:0]       ret_vec;
    logic [VC_NUM-1:0]       use_vec;

    function automatic logic [VC_NUM_IDX_W-1:0] wrap_inc(input logic [VC_NUM_IDX_W-1:0] idx);
        if (32'(idx) >= 32'(VC_NUM - 1)) begin
            return '0;
        end
        return idx + VC_NUM_IDX_W'(1);
    endfunction

    // A return on a full counter saturates; a same-cycle consume cancels a return.
    function automatic logic [CRD_W-1:0] crd_update(input logic [CRD_W-1:0] cur,
                                                    input logic inc, input logic dec);
        logic [CRD_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec && (cur != CRD_FULL)) begin
            nxt = cur + CRD_W'(1);
        end else if (dec && !inc) begin
            nxt = cur - CRD_W'(1);
        end
        return nxt;
    endfunction

    always_comb begin
        eligible = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            eligible[i] = req_vc_mask_i[i] && (crd_q[i] != '0);
        end
    end

    assign req_rdy_o = |eligible;
    assign hs        = req_vld_i && req_rdy_o;

    // Round-robin search starting at rr_ptr, wrapping at the top VC.
    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        scan_idx    = rr_ptr_q;
        for (int k = 0; k < VC_NUM; k++) begin
            if (!grant_found && eligible[scan_idx]) begin
                grant_found        = 1'b1;
                grant_oh[scan_idx] = 1'b1;
                grant_idx          = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    assign lcrd_id_ext   = 32'(lcrd_id_i);
    assign lcrd_in_range = lcrd_id_ext < 32'(VC_NUM);

    always_comb begin
        ret_vec = '0;
        use_vec = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            ret_vec[i] = lcrd_v_i && lcrd_in_range && (lcrd_id_ext == 32'(i));
            use_vec[i] = hs && grant_oh[i];
        end
    end

    always_comb begin
        crd_err_d = crd_err_q;
        if (lcrd_v_i && !lcrd_in_range) begin
            crd_err_d = 1'b1;
        end
        for (int i = 0; i < VC_NUM; i++) begin
            crd_d[i] = crd_update(crd_q[i], ret_vec[i], use_vec[i]);
            if (ret_vec[i] && !use_vec[i] && (crd_q[i] == CRD_FULL)) begin
                crd_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        flit_v_d   = hs;
        flit_d     = flit_q;
        flit_dec_d = flit_dec_q;
        vc_id_d    = vc_id_q;
        if (hs) begin
            rr_ptr_d   = wrap_inc(grant_idx);
            flit_d     = req_flit_i;
            flit_dec_d = req_dec_i;
            vc_id_d    = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VC_NUM; i++) begin
                crd_q[i] <= CRD_FULL;
            end
            rr_ptr_q   <= '0;
            crd_err_q  <= 1'b0;
            flit_v_q   <= 1'b0;
            flit_q     <= '0;
            flit_dec_q <= '0;
            vc_id_q    <= '0;
        end else begin
            for (int i = 0; i < VC_NUM; i++) begin
                crd_q[i] <= crd_d[i];
            end
            rr_ptr_q   <= rr_ptr_d;
            crd_err_q  <= crd_err_d;
            flit_v_q   <= flit_v_d;
            flit_q     <= flit_d;
            flit_dec_q <= flit_dec_d;
            vc_id_q    <= vc_id_d;
        end
    end

    always_comb begin
        crd_cnt_o = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            crd_cnt_o[i*CRD_W +: CRD_W] = crd_q[i];
        end
    end

    assign flit_v_o     = flit_v_q;
    assign flit_o       = flit_q;
    assign flit_dec_o   = flit_dec_q;
    assign flit_vc_id_o = vc_id_q;
    assign crd_err_o    = crd_err_q;

endmodule

// File: tb/tb_output_port_vc_credit.sv
// Scoreboard bench for output_port_vc_credit: stimulus pushes expected launches, a monitor pops and compares.
module tb_output_port_vc_credit;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_vld_i = 1'b0;
    logic [255:0] req_flit_i = '0;
    logic [31:0]  req_dec_i = '0;
    logic [3:0]   req_vc_mask_i = '0;
    logic         req_rdy_o;
    logic         flit_v_o;
    logic [255:0] flit_o;
    logic [31:0]  flit_dec_o;
    logic [1:0]   flit_vc_id_o;
    logic         lcrd_v_i = 1'b0;
    logic [2:0]   lcrd_id_i = '0;
    logic [7:0]   crd_cnt_o;
    logic         crd_err_o;

    output_port_vc_credit dut (
        .clk(clk), .rst(rst),
        .req_vld_i(req_vld_i), .req_flit_i(req_flit_i), .req_dec_i(req_dec_i),
        .req_vc_mask_i(req_vc_mask_i), .req_rdy_o(req_rdy_o),
        .flit_v_o(flit_v_o), .flit_o(flit_o), .flit_dec_o(flit_dec_o),
        .flit_vc_id_o(flit_vc_id_o),
        .lcrd_v_i(lcrd_v_i), .lcrd_id_i(lcrd_id_i),
        .crd_cnt_o(crd_cnt_o), .crd_err_o(crd_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           vc;
        logic [255:0] data;
        logic [31:0]  dec;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   tag = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every launched flit must match the oldest outstanding handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (flit_v_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flit: got vc %0d expected no flit", flit_vc_id_o);
                end else begin
                    e = sb.pop_front();
                    chk("flit_vc_id", 256'(flit_vc_id_o), 256'(e.vc));
                    chk("flit_data", flit_o, e.data);
                    chk("flit_dec", 256'(flit_dec_o), 256'(e.dec));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_flit: got no flit expected vc %0d", sb[0].vc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input logic vld, input logic [3:0] mask, input logic lv,
                         input logic [2:0] lid, input logic rdy_exp, input int vc_exp,
                         input logic track);
        exp_t e;
        tag++;
        req_vld_i     = vld;
        req_vc_mask_i = mask;
        lcrd_v_i      = lv;
        lcrd_id_i     = lid;
        req_flit_i    = {8{32'(tag) ^ 32'h1234_0000}};
        req_dec_i     = 32'(tag) ^ 32'hA5A5_0000;
        @(negedge clk);
        chk("req_rdy", 256'(req_rdy_o), 256'(rdy_exp));
        if (vld && rdy_exp && track) begin
            e.vc   = vc_exp;
            e.data = req_flit_i;
            e.dec  = req_dec_i;
            e.due  = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] mask, input int vc);
        drive(1'b1, mask, 1'b0, 3'd0, 1'b1, vc, 1'b1);
    endtask

    task automatic blocked(input logic [3:0] mask, input logic lv, input logic [2:0] lid);
        drive(1'b1, mask, lv, lid, 1'b0, 0, 1'b1);
    endtask

    task automatic idle(input logic lv, input logic [2:0] lid);
        drive(1'b0, 4'b0000, lv, lid, 1'b0, 0, 1'b1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_vld_i = 1'b0;
        lcrd_v_i  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_flit_v", 256'(flit_v_o), 256'(0));
        chk("rst_flit", flit_o, 256'(0));
        chk("rst_dec", 256'(flit_dec_o), 256'(0));
        chk("rst_vc_id", 256'(flit_vc_id_o), 256'(0));
        chk("rst_crd", 256'(crd_cnt_o), 256'(8'hAA));
        chk("rst_err", 256'(crd_err_o), 256'(0));
        drive(1'b0, 4'b1111, 1'b0, 3'd0, 1'b1, 0, 1'b1);
        blocked(4'b0000, 1'b0, 3'd0);

        // Round robin across all VCs until credits are exhausted
        for (int i = 0; i < 8; i++) send(4'b1111, i % 4);
        chk("rr_crd_empty", 256'(crd_cnt_o), 256'(8'h00));
        blocked(4'b1111, 1'b0, 3'd0);
        idle(1'b0, 3'd0);

        // Single VC loop with credit return
        do_reset();
        send(4'b0100, 2);
        send(4'b0100, 2);
        blocked(4'b0100, 1'b1, 3'd2);
        send(4'b0100, 2);
        idle(1'b0, 3'd0);
        chk("vc2_crd", 256'(crd_cnt_o), 256'(8'h8A));

        // Return at zero credit is not visible until next cycle
        do_reset();
        send(4'b0010, 1);
        send(4'b0010, 1);
        blocked(4'b0010, 1'b1, 3'd1);
        send(4'b0010, 1);
        idle(1'b0, 3'd0);
        chk("vc1_crd", 256'(crd_cnt_o), 256'(8'hA2));

        // Simultaneous consume and return on VC0
        do_reset();
        send(4'b0001, 0);
        drive(1'b1, 4'b0001, 1'b1, 3'd0, 1'b1, 0, 1'b1);
        idle(1'b0, 3'd0);
        chk("vc0_same_cycle_crd", 256'(crd_cnt_o), 256'(8'hA9));
        chk("vc0_same_cycle_err", 256'(crd_err_o), 256'(0));

        // Overflow return and out-of-range id
        do_reset();
        idle(1'b1, 3'd0);
        chk("ovf_crd", 256'(crd_cnt_o), 256'(8'hAA));
        chk("ovf_err", 256'(crd_err_o), 256'(1));
        idle(1'b0, 3'd0);
        idle(1'b0, 3'd0);
        chk("ovf_err_sticky", 256'(crd_err_o), 256'(1));
        do_reset();
        chk("err_cleared", 256'(crd_err_o), 256'(0));
        idle(1'b1, 3'd5);
        chk("badid_crd", 256'(crd_cnt_o), 256'(8'hAA));
        chk("badid_err", 256'(crd_err_o), 256'(1));

        // Reset in the cycle after a handshake drops the in-flight launch
        do_reset();
        send(4'b1111, 0);
        drive(1'b1, 4'b1111, 1'b0, 3'd0, 1'b1, 1, 1'b0);
        chk("pre_rst_flit_v", 256'(flit_v_o), 256'(1));
        req_vld_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_flit_v", 256'(flit_v_o), 256'(0));
        chk("async_rst_crd", 256'(crd_cnt_o), 256'(8'hAA));
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(4'b1111, 0);
        idle(1'b0, 3'd0);

        chk("sb_empty", 256'(sb.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
